// File: rtl/mdu_hilo_if.sv
// Request/response bundle between decode, register-write and the HI/LO multiply/divide unit.
// The master side issues operations and reads; the slave side is the unit itself.
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_en;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, rd_en, rd_sel,
    input  rd_data, rd_stall, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, rd_en, rd_sel,
    output rd_data, rd_stall, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair: one shift-add or restoring-divide
// step per cycle on magnitudes, followed by a single sign-fixup/accumulate cycle.
module mdu_hilo (
  input logic         clk,
  input logic         rst,
  mdu_hilo_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_MADD = 3'd2, OP_MADDU = 3'd3,
    OP_DIV   = 3'd4, OP_DIVU  = 3'd5, OP_MTHI = 3'd6, OP_MTLO  = 3'd7
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d, reqOp;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opB_q, opB_d;
  logic        prodNeg_q, prodNeg_d;
  logic        remNeg_q, remNeg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        reqSigned, reqDiv, runDiv, runMadd;
  logic [31:0] rsAbs, rtAbs;
  logic [32:0] mulSum;
  logic        divGeq;
  logic [31:0] divDiff;
  logic [63:0] prodSigned, hiloSum;
  logic [31:0] quo, rem;

  assign reqOp     = op_e'(bus.op);
  assign reqSigned = (reqOp == OP_MULT) || (reqOp == OP_MADD) || (reqOp == OP_DIV);
  assign reqDiv    = (reqOp == OP_DIV) || (reqOp == OP_DIVU);
  assign runDiv    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign runMadd   = (op_q == OP_MADD) || (op_q == OP_MADDU);

  // Negating 0x8000_0000 wraps back to itself, which is the intended unsigned magnitude.
  assign rsAbs = (reqSigned && bus.rs_val[31]) ? (~bus.rs_val + 32'd1) : bus.rs_val;
  assign rtAbs = (reqSigned && bus.rt_val[31]) ? (~bus.rt_val + 32'd1) : bus.rt_val;

  // Multiply keeps the multiplier in acc[31:0] and shifts the partial product in from the top.
  assign mulSum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opB_q : 32'd0)};

  // Divide: acc = {remainder, quotient}; the shifted remainder is acc[63:31] (33 bits).
  assign divGeq  = acc_q[63:31] >= {1'b0, opB_q};
  assign divDiff = acc_q[62:31] - opB_q;

  assign prodSigned = prodNeg_q ? (~acc_q + 64'd1) : acc_q;
  assign hiloSum    = {hi_q, lo_q} + prodSigned;
  assign quo        = prodNeg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem        = remNeg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opB_d     = opB_q;
    prodNeg_d = prodNeg_q;
    remNeg_d  = remNeg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (reqOp)
            OP_MTHI: begin
              hi_d   = bus.rs_val;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.rs_val;
              done_d = 1'b1;
            end
            default: begin
              if (reqDiv && (bus.rt_val == 32'd0)) begin
                hi_d   = bus.rs_val;
                lo_d   = 32'hFFFF_FFFF;
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                op_d      = reqOp;
                cnt_d     = 6'd0;
                state_d   = RUN;
                prodNeg_d = reqSigned & (bus.rs_val[31] ^ bus.rt_val[31]);
                remNeg_d  = reqSigned & bus.rs_val[31];
                if (reqDiv) begin
                  acc_d = {32'd0, rsAbs};
                  opB_d = rtAbs;
                end else begin
                  acc_d = {32'd0, rtAbs};
                  opB_d = rsAbs;
                end
              end
            end
          endcase
        end
      end

      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (runDiv) begin
          if (divGeq) acc_d = {divDiff, acc_q[30:0], 1'b1};
          else        acc_d = {acc_q[62:0], 1'b0};
        end else begin
          acc_d = {mulSum, acc_q[31:1]};
        end
        if (cnt_q == 6'd31) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (runDiv) begin
          lo_d = quo;
          hi_d = rem;
        end else if (runMadd) begin
          {hi_d, lo_d} = hiloSum;
        end else begin
          {hi_d, lo_d} = prodSigned;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opB_q     <= 32'd0;
      prodNeg_q <= 1'b0;
      remNeg_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opB_q     <= opB_d;
      prodNeg_q <= prodNeg_d;
      remNeg_q  <= remNeg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.rd_stall    = bus.rd_en & (state_q != IDLE);
  assign bus.rd_data     = bus.rd_sel ? hi_q : lo_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
